qsn_shift_ctrl: RTL and testbench

- Upstream control stage for the Pc=5 quasi-cyclic shift network (QSN) pair, i.e. the right and left rotate networks.
- For each column block of the current layer it takes the absolute circulant shift factor and looks up the shift last applied to that column.
- It issues the relative shift (delta) as the right-network select, the complementary left-network select, and the output merge mask.
- Output is a registered valid/ready stream that feeds the QSN datapath stage.

---
 rtl/qsn_shift_ctrl.sv | 152 +++++++++++++++
 tb/tb_qsn_shift_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsn_shift_ctrl.sv
// qsn_shift_ctrl: control stage ahead of the right/left quasi-cyclic rotate pair.
// Turns absolute circulant shifts into relative deltas against the shift last
// applied to each column, and issues a registered select bundle downstream.
module qsn_shift_ctrl #(
    parameter int PC      = 5,
    parameter int SEL_W   = 3,
    parameter int COL_NUM = 10,
    parameter int COL_W   = 4
) (
    input  logic               sys_clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               clear_mem,
    input  logic               shift_in_valid,
    output logic               shift_in_ready,
    input  logic [SEL_W-1:0]   shift_in,
    input  logic [COL_W-1:0]   col_idx,
    input  logic               last_col,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   sel_right,
    output logic [SEL_W-1:0]   sel_left,
    output logic [PC-1:0]      merge_mask,
    output logic [COL_W-1:0]   out_col,
    output logic               layer_done,
    output logic               shift_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [SEL_W-1:0]   mem [COL_NUM];

    logic               accept;
    logic               shift_ok;
    logic               col_ok;
    logic [SEL_W-1:0]   eff_shift;
    logic [SEL_W-1:0]   mem_rd;
    logic [SEL_W:0]     diff_raw;
    logic [SEL_W:0]     diff_wrap;
    logic [SEL_W-1:0]   delta;
    logic [SEL_W-1:0]   left_nxt;
    logic [PC-1:0]      mask_nxt;

    assign accept = shift_in_valid && shift_in_ready;

    // Delta arithmetic: clamp bad shifts, read the column's last shift, wrap mod PC.
    always_comb begin
        shift_ok  = {1'b0, shift_in} < (SEL_W+1)'(PC);
        col_ok    = {1'b0, col_idx} < (COL_W+1)'(COL_NUM);
        eff_shift = shift_ok ? shift_in : '0;
        mem_rd    = '0;
        for (int i = 0; i < COL_NUM; i++) begin
            if (col_idx == COL_W'(i)) begin
                mem_rd = mem[i];
            end
        end
        diff_raw  = {1'b0, eff_shift} - {1'b0, mem_rd};
        diff_wrap = diff_raw[SEL_W] ? (diff_raw + (SEL_W+1)'(PC)) : diff_raw;
        delta     = diff_wrap[SEL_W-1:0];
        left_nxt  = (delta == '0) ? '0 : (SEL_W'(PC) - delta);
        mask_nxt  = '0;
        for (int i = 0; i < PC; i++) begin
            mask_nxt[i] = (SEL_W'(i) >= delta);
        end
    end

    // Layer sequencing and input-side ready.
    always_comb begin
        state_nxt      = state;
        shift_in_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                shift_in_ready = !out_valid || out_ready;
                if (shift_in_valid && (!out_valid || out_ready) && last_col) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Per-column shift memory: cleared on reset or an idle clear, updated on accept.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            for (int i = 0; i < COL_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (state == IDLE && clear_mem) begin
            for (int i = 0; i < COL_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && col_ok) begin
            for (int i = 0; i < COL_NUM; i++) begin
                if (col_idx == COL_W'(i)) begin
                    mem[i] <= eff_shift;
                end
            end
        end
    end

    // Output bundle register plus the one-cycle status pulses.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            sel_right  <= '0;
            sel_left   <= '0;
            merge_mask <= '0;
            out_col    <= '0;
            layer_done <= 1'b0;
            shift_err  <= 1'b0;
        end else begin
            layer_done <= (state == DRAIN) && out_valid && out_ready;
            shift_err  <= accept && (!shift_ok || !col_ok);
            if (accept) begin
                out_valid  <= 1'b1;
                sel_right  <= delta;
                sel_left   <= left_nxt;
                merge_mask <= mask_nxt;
                out_col    <= col_idx;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qsn_shift_ctrl.sv
// tb_qsn_shift_ctrl: directed and randomized layers checked against a
// cycle-level behavioural model of the shift controller.
module tb_qsn_shift_ctrl;

    localparam int PC      = 5;
    localparam int SEL_W   = 3;
    localparam int COL_NUM = 10;
    localparam int COL_W   = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic               sys_clk = 1'b0;
    logic               rstn;
    logic               start;
    logic               clear_mem;
    logic               shift_in_valid;
    logic               shift_in_ready;
    logic [SEL_W-1:0]   shift_in;
    logic [COL_W-1:0]   col_idx;
    logic               last_col;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   sel_right;
    logic [SEL_W-1:0]   sel_left;
    logic [PC-1:0]      merge_mask;
    logic [COL_W-1:0]   out_col;
    logic               layer_done;
    logic               shift_err;

    int check_cnt = 0;
    int error_cnt = 0;

    // Behavioural model state
    int   m_mem [COL_NUM];
    int   m_state = M_IDLE;
    logic m_valid = 1'b0;
    int   m_sel_r = 0;
    int   m_sel_l = 0;
    int   m_mask  = 0;
    int   m_col   = 0;
    logic m_done  = 1'b0;
    logic m_err   = 1'b0;

    // Handshake counters observed on the DUT pins
    int dut_consumed = 0;
    int dut_done     = 0;

    always #5 sys_clk = ~sys_clk;

    qsn_shift_ctrl #(
        .PC      (PC),
        .SEL_W   (SEL_W),
        .COL_NUM (COL_NUM),
        .COL_W   (COL_W)
    ) dut (
        .sys_clk        (sys_clk),
        .rstn           (rstn),
        .start          (start),
        .clear_mem      (clear_mem),
        .shift_in_valid (shift_in_valid),
        .shift_in_ready (shift_in_ready),
        .shift_in       (shift_in),
        .col_idx        (col_idx),
        .last_col       (last_col),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .sel_right      (sel_right),
        .sel_left       (sel_left),
        .merge_mask     (merge_mask),
        .out_col        (out_col),
        .layer_done     (layer_done),
        .shift_err      (shift_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_cnt++;
        if (observed !== expected) begin
            error_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("out_valid",  out_valid,  m_valid);
        checkOutput("sel_right",  sel_right,  m_sel_r);
        checkOutput("sel_left",   sel_left,   m_sel_l);
        checkOutput("merge_mask", merge_mask, m_mask);
        checkOutput("out_col",    out_col,    m_col);
        checkOutput("layer_done", layer_done, m_done);
        checkOutput("shift_err",  shift_err,  m_err);
    endtask

    task automatic modelStep(input logic st, input logic cm, input logic v, input int sh, input int col,
                             input logic lc, input logic ordy, input logic rn, output logic acc);
        logic ready;
        logic consumed;
        logic in_range;
        int   eff;
        int   base;
        int   delta;
        ready    = (m_state == M_RUN) && (!m_valid || ordy);
        acc      = rn && ready && v;
        consumed = m_valid && ordy;
        if (!rn) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_state = M_IDLE;
            m_valid = 1'b0;
            m_sel_r = 0;
            m_sel_l = 0;
            m_mask  = 0;
            m_col   = 0;
            m_done  = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_done = (m_state == M_DRAIN) && consumed;
            m_err  = 1'b0;
            if (acc) begin
                in_range = (col < COL_NUM);
                eff      = (sh < PC) ? sh : 0;
                base     = in_range ? m_mem[col] : 0;
                delta    = ((eff - base) % PC + PC) % PC;
                m_sel_r  = delta;
                m_sel_l  = (PC - delta) % PC;
                m_mask   = ((1 << PC) - 1) & ~((1 << delta) - 1);
                m_col    = col;
                m_valid  = 1'b1;
                m_err    = (sh >= PC) || !in_range;
                if (in_range) m_mem[col] = eff;
            end else if (consumed) begin
                m_valid = 1'b0;
            end
            case (m_state)
                M_IDLE: begin
                    if (cm) foreach (m_mem[i]) m_mem[i] = 0;
                    if (st) m_state = M_RUN;
                end
                M_RUN: begin
                    if (acc && lc) m_state = M_DRAIN;
                end
                default: begin
                    if (consumed) m_state = M_IDLE;
                end
            endcase
        end
    endtask

    // One clock cycle: drive after the falling edge, check ready, clock the model, check outputs.
    task automatic applyStimulus(input logic st, input logic cm, input logic v, input int sh, input int col,
                                 input logic lc, input logic ordy, input logic rn, output logic acc);
        start          = st;
        clear_mem      = cm;
        shift_in_valid = v;
        shift_in       = SEL_W'(sh);
        col_idx        = COL_W'(col);
        last_col       = lc;
        out_ready      = ordy;
        rstn           = rn;
        #1;
        checkOutput("shift_in_ready", shift_in_ready, (m_state == M_RUN) && (!m_valid || ordy));
        if (rn && out_valid === 1'b1 && out_ready) dut_consumed++;
        @(posedge sys_clk);
        modelStep(st, cm, v, sh, col, lc, ordy, rn, acc);
        @(negedge sys_clk);
        checkAll();
        if (layer_done === 1'b1) dut_done++;
    endtask

    task automatic probe(input string tag, input int r, input int l, input int m);
        checkOutput({tag, "_sel_right"},  sel_right,  r);
        checkOutput({tag, "_sel_left"},   sel_left,   l);
        checkOutput({tag, "_merge_mask"}, merge_mask, m);
    endtask

    task automatic drainLayer(input logic rnd);
        logic acc;
        int   tries;
        tries = 0;
        while (m_state != M_IDLE && tries < 50) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, rnd ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b1, acc);
            tries++;
        end
        if (m_state != M_IDLE) checkOutput("drain_timeout", 0, 1);
    endtask

    // mode 0: shift = col mod PC; mode 1: random legal shifts; mode 2: fully random traffic
    task automatic runLayer(input logic clr, input int mode, input int stall_from, input int stall_len,
                            input int probe_col, input int pr, input int pl, input int pm);
        logic acc;
        logic ordy;
        logic v;
        int   tries;
        int   cyc;
        int   sh;
        int   col;
        int   c0;
        int   d0;
        c0  = dut_consumed;
        d0  = dut_done;
        cyc = 0;
        applyStimulus(1'b1, clr, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, acc);
        for (int c = 0; c < COL_NUM; c++) begin
            acc   = 1'b0;
            tries = 0;
            sh    = (mode == 0) ? (c % PC) : (mode == 1) ? $urandom_range(0, PC - 1) : $urandom_range(0, 7);
            col   = (mode == 2 && $urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : c;
            while (!acc && tries < 50) begin
                ordy = !(cyc >= stall_from && cyc < stall_from + stall_len);
                v    = 1'b1;
                if (mode == 2) begin
                    ordy = ($urandom_range(0, 3) != 0);
                    v    = ($urandom_range(0, 3) != 0);
                end
                applyStimulus(1'b0, 1'b0, v, sh, col, (c == COL_NUM - 1), ordy, 1'b1, acc);
                tries++;
                cyc++;
            end
            if (!acc) checkOutput("accept_timeout", 0, 1);
            if (acc && c == probe_col) probe("probe", pr, pl, pm);
        end
        drainLayer(mode == 2);
        checkOutput("bundle_count", dut_consumed - c0, COL_NUM);
        checkOutput("layer_done_count", dut_done - d0, 1);
    endtask

    initial begin
        logic acc;
        int   d0;
        int   c0;

        start = 1'b0; clear_mem = 1'b0; shift_in_valid = 1'b0; shift_in = '0;
        col_idx = '0; last_col = 1'b0; out_ready = 1'b1; rstn = 1'b0;
        foreach (m_mem[i]) m_mem[i] = 0;
        @(negedge sys_clk);

        // Reset
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_merge_mask", merge_mask, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, acc);

        // Layer 1: shift = col mod 5, probe column 3
        $display("[TB] layer 1: sequential shifts");
        runLayer(1'b1, 0, -1, 0, 3, 3, 2, 5'b11000);

        // Layer 2: col2 against mem[2]=2, zero delta then wrapped delta
        $display("[TB] layer 2: delta zero and wrap");
        c0 = dut_consumed;
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 1'b0, 1'b1, 2, 2, 1'b0, 1'b1, 1'b1, acc);
        probe("col2_delta0", 0, 0, 5'b11111);
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 2, 1'b1, 1'b1, 1'b1, acc);
        probe("col2_wrap", 4, 1, 5'b10000);
        drainLayer(1'b0);
        checkOutput("layer2_bundles", dut_consumed - c0, 2);

        // Back-pressure: out_ready low for 4 cycles mid-layer
        $display("[TB] layer 3: back-pressure");
        runLayer(1'b0, 1, 3, 4, -1, 0, 0, 0);

        // Out-of-range shift and column index
        $display("[TB] layer 4: error cases");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 1'b0, 1'b1, 6, 1, 1'b0, 1'b1, 1'b1, acc);
        checkOutput("bad_shift_err", shift_err, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 3, 12, 1'b0, 1'b1, 1'b1, acc);
        checkOutput("bad_col_err", shift_err, 1);
        probe("bad_col", 3, 2, 5'b11000);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 4, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 1'b0, 1'b1, 2, 1, 1'b1, 1'b1, 1'b1, acc);
        probe("mem1_zeroed", 2, 3, 5'b11100);
        checkOutput("no_err_pulse", shift_err, 0);
        drainLayer(1'b0);

        // Same column twice back-to-back from a cleared memory
        $display("[TB] layer 5: same column back-to-back");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 1'b0, 1'b1, 4, 5, 1'b0, 1'b1, 1'b1, acc);
        probe("b2b_first", 4, 1, 5'b10000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 5, 1'b1, 1'b1, 1'b1, acc);
        probe("b2b_second", 2, 3, 5'b11100);
        drainLayer(1'b0);

        // Reset in the middle of a layer, with a stray start while running
        $display("[TB] layer 6: reset mid-layer");
        d0 = dut_done;
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 1'b0, 1'b1, 2, 0, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b1, 1'b1, 1'b1, 3, 1, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 1'b0, 1'b1, 4, 2, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 3, 1'b0, 1'b0, 1'b0, acc);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_sel_right", sel_right, 0);
        checkOutput("midrst_out_col", out_col, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 3, 1'b0, 1'b1, 1'b1, acc);
        checkOutput("midrst_idle_ready", shift_in_ready, 0);
        checkOutput("midrst_no_done", dut_done - d0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 1'b0, 1'b1, 3, 0, 1'b1, 1'b1, 1'b1, acc);
        probe("after_rst_mem0", 3, 2, 5'b11000);
        drainLayer(1'b0);

        // Randomized layers
        $display("[TB] randomized layers");
        for (int k = 0; k < 8; k++) begin
            runLayer($urandom_range(0, 1) == 1, 2, -1, 0, -1, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
